// File: rtl/onehot_decoder_2_4_pkg.sv
// Shared definitions for the 2-to-4 one-hot pulse decoder: FSM states,
// line-index constants and the hold counter width.
package onehot_decoder_2_4_pkg;

  localparam int CNT_W = 8;

  localparam logic [1:0] A0 = 2'd0;
  localparam logic [1:0] A1 = 2'd1;
  localparam logic [1:0] A2 = 2'd2;
  localparam logic [1:0] A3 = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/onehot_decoder_2_4_dec2to4.sv
// Pure combinational 2-bit index to 4-bit one-hot conversion.
module dec2to4
  import onehot_decoder_2_4_pkg::*;
(
  input  logic [1:0] b,
  output logic [3:0] a
);

  // index to one-hot lookup
  always_comb begin
    a = 4'b0000;
    case (b)
      A0:      a = 4'b0001;
      A1:      a = 4'b0010;
      A2:      a = 4'b0100;
      A3:      a = 4'b1000;
      default: a = 4'b0000;
    endcase
  end

endmodule

// File: rtl/onehot_decoder_2_4.sv
// One-hot pulse decoder: an accepted {b,v} drives line a[b] for HOLD_CYCLES
// cycles followed by a one-cycle gap. Optional err_cnt via ONEHOT_DEC_ERRCNT_EN.
module onehot_decoder_2_4
  import onehot_decoder_2_4_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] b,
  input  logic       v,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] a,
  output logic       busy,
  output logic       no_valid
`ifdef ONEHOT_DEC_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_e           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [3:0]       a_r, a_s;
  logic             busy_r, busy_s;
  logic             no_valid_r, no_valid_s;
  logic [3:0]       line_s;
  logic             in_ready_s;
  logic             xfer_s;

  dec2to4 u_dec (
    .b (b),
    .a (line_s)
  );

  assign in_ready_s = enable && (state_r == IDLE);
  assign xfer_s     = in_valid && in_ready_s;

  // next-state, counter and output line computation
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    a_s        = a_r;
    no_valid_s = 1'b0;
    if (!enable) begin
      // disabling aborts any pulse outright; it is never resumed
      state_s = IDLE;
      cnt_s   = 8'd0;
      a_s     = 4'b0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (xfer_s && v) begin
            a_s     = line_s;
            cnt_s   = HOLD_LOAD;
            state_s = PULSE;
          end else if (xfer_s) begin
            no_valid_s = 1'b1;
          end else begin
            no_valid_s = 1'b0;
          end
        end
        PULSE: begin
          if (cnt_r == 8'd0) begin
            a_s     = 4'b0000;
            state_s = GAP;
          end else begin
            cnt_s = cnt_r - 8'd1;
          end
        end
        GAP: begin
          a_s     = 4'b0000;
          state_s = IDLE;
        end
        default: begin
          a_s     = 4'b0000;
          cnt_s   = 8'd0;
          state_s = IDLE;
        end
      endcase
    end
    busy_s = (state_s != IDLE);
  end

  // state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      a_r        <= 4'b0000;
      busy_r     <= 1'b0;
      no_valid_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      a_r        <= a_s;
      busy_r     <= busy_s;
      no_valid_r <= no_valid_s;
    end
  end

  assign in_ready = in_ready_s;
  assign a        = a_r;
  assign busy     = busy_r;
  assign no_valid = no_valid_r;

`ifdef ONEHOT_DEC_ERRCNT_EN
  logic [7:0] err_cnt_r;

  // saturating count of accepted v=0 transfers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_r <= 8'd0;
    end else if (no_valid_s && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_onehot_decoder_2_4.sv
// Scoreboard bench for onehot_decoder_2_4: directed and random transfers,
// a pulse-level reference model, plus a HOLD_CYCLES=1 instance.
module tb_onehot_decoder_2_4;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic [1:0] b = 2'b00;
  logic       v = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] a;
  logic       busy;
  logic       no_valid;

  logic       rst2 = 1'b1;
  logic       in_ready2;
  logic [3:0] a2;
  logic       busy2;
  logic       no_valid2;
`ifdef ONEHOT_DEC_ERRCNT_EN
  logic [7:0] err_cnt;
  logic [7:0] err_cnt2;
`endif

  onehot_decoder_2_4 #(.HOLD_CYCLES(H)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .b        (b),
    .v        (v),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .busy     (busy),
    .no_valid (no_valid)
`ifdef ONEHOT_DEC_ERRCNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  onehot_decoder_2_4 #(.HOLD_CYCLES(1)) dut1 (
    .clk      (clk),
    .rst      (rst2),
    .enable   (1'b1),
    .b        (2'b01),
    .v        (1'b1),
    .in_valid (1'b1),
    .in_ready (in_ready2),
    .a        (a2),
    .busy     (busy2),
    .no_valid (no_valid2)
`ifdef ONEHOT_DEC_ERRCNT_EN
    ,
    .err_cnt  (err_cnt2)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // expected pulses: line value, length in cycles, first cycle number
  int exp_val_q[$];
  int exp_len_q[$];
  int exp_start_q[$];
  int nv_q[$];

  int free_cyc = 0;   // first cycle at which the block is idle again
  int last_t = 0;
  bit last_v = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      check("in_ready", int'(in_ready), int'(enable && (cyc >= free_cyc)));
      check("busy", int'(busy), int'(cyc < free_cyc));
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input logic [1:0] bb, input logic vv);
    int w;
    int t;
    w = 0;
    b = bb;
    v = vv;
    in_valid = 1'b1;
    #1;
    while (!in_ready && w < 200) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
    end else begin
      t = cyc + 1;
      if (vv) begin
        exp_val_q.push_back(1 << bb);
        exp_len_q.push_back(H);
        exp_start_q.push_back(t);
        free_cyc = t + H + 1;
      end else begin
        nv_q.push_back(t);
      end
      last_t = t;
      last_v = vv;
    end
    tick();
    in_valid = 1'b0;
  endtask

  // drop enable during the k-th cycle after the last transfer edge
  task automatic abort_after(input int k);
    int e;
    repeat (k - 1) tick();
    enable = 1'b0;
    e = cyc + 1;
    if (last_v && (e - last_t) <= H && exp_len_q.size() > 0)
      exp_len_q[exp_len_q.size() - 1] = e - last_t;
    last_v = 1'b0;
    if (e < free_cyc) free_cyc = e;
    repeat (3) tick();
    enable = 1'b1;
  endtask

  // monitor: reconstructs pulses on a and retires them against the queues
  int cur_len = 0;
  int cur_val = 0;
  int cur_start = 0;
  always @(negedge clk) begin
    int ev, el, es, tok;
    if (rst) begin
      cur_len = 0;
    end else begin
      if (no_valid) begin
        checks++;
        if (nv_q.size() == 0) begin
          failures++;
          $display("FAIL no_valid actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          tok = nv_q.pop_front();
          if (tok != cyc) begin
            failures++;
            $display("FAIL no_valid_cycle actual=%0d expected=%0d", cyc, tok);
          end
        end
      end
      if (a != 4'b0000) begin
        if (cur_len == 0) begin
          cur_val = int'(a);
          cur_start = cyc;
        end else if (int'(a) != cur_val) begin
          checks++;
          failures++;
          $display("FAIL a_change actual=%b expected=%b (cycle %0d)", a, cur_val[3:0], cyc);
        end
        cur_len++;
      end else if (cur_len != 0) begin
        checks++;
        if (exp_val_q.size() == 0) begin
          failures++;
          $display("FAIL pulse_unexpected actual=%b expected=none", cur_val[3:0]);
        end else begin
          ev = exp_val_q.pop_front();
          el = exp_len_q.pop_front();
          es = exp_start_q.pop_front();
          if (cur_val != ev || cur_len != el || cur_start != es) begin
            failures++;
            $display("FAIL pulse actual=%b/len%0d/at%0d expected=%b/len%0d/at%0d",
                     cur_val[3:0], cur_len, cur_start, ev[3:0], el, es);
          end
        end
        cur_len = 0;
      end
    end
  end

  initial begin
    logic [1:0] rb;
    logic       rv;
    #1;
    check("reset_a", int'(a), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_no_valid", int'(no_valid), 0);
`ifdef ONEHOT_DEC_ERRCNT_EN
    check("reset_err_cnt", int'(err_cnt), 0);
`endif
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    free_cyc = cyc;
    tick();

    // single b=11 pulse, then idle
    send(2'b11, 1'b1);
    idle(8);

    // b=00,01,10 with in_valid held until each is accepted
    send(2'b00, 1'b1);
    send(2'b01, 1'b1);
    send(2'b10, 1'b1);
    idle(8);

    // v=0 transfers and error counting
    send(2'($urandom_range(0, 3)), 1'b0);
`ifdef ONEHOT_DEC_ERRCNT_EN
    check("err_cnt_first", int'(err_cnt), 1);
`endif
    for (int i = 0; i < 299; i++) send(2'($urandom_range(0, 3)), 1'b0);
`ifdef ONEHOT_DEC_ERRCNT_EN
    check("err_cnt_saturated", int'(err_cnt), 255);
`endif
    idle(3);

    // enable drop during the 2nd cycle of a b=10 pulse
    send(2'b10, 1'b1);
    abort_after(2);
    idle(3);

    // asynchronous reset in mid-pulse
    send(2'b10, 1'b1);
    check("pre_reset_a", int'(a), 4);
    #2 rst = 1'b1;
    #1;
    check("async_reset_a", int'(a), 0);
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_no_valid", int'(no_valid), 0);
    exp_val_q.delete();
    exp_len_q.delete();
    exp_start_q.delete();
    nv_q.delete();
    last_v = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    free_cyc = cyc;
    send(2'b01, 1'b1);
    idle(7);

    // randomized traffic with occasional aborts
    for (int i = 0; i < 80; i++) begin
      idle($urandom_range(0, 2));
      rb = 2'($urandom_range(0, 3));
      rv = ($urandom_range(0, 3) != 0);
      send(rb, rv);
      if ($urandom_range(0, 4) == 0) abort_after($urandom_range(1, H + 1));
    end
    idle(H + 4);
    check("pending_pulses", exp_val_q.size(), 0);
    check("pending_no_valid", nv_q.size(), 0);
    check("pulse_in_progress", cur_len, 0);

    // HOLD_CYCLES=1 instance, in_valid permanently high on b=01
    @(negedge clk);
    #2 rst2 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("h1_a", int'(a2), (i % 3 == 0) ? 2 : 0);
      check("h1_busy", int'(busy2), (i % 3 != 2) ? 1 : 0);
      check("h1_in_ready", int'(in_ready2), (i % 3 == 2) ? 1 : 0);
      check("h1_no_valid", int'(no_valid2), 0);
    end
`ifdef ONEHOT_DEC_ERRCNT_EN
    check("h1_err_cnt", int'(err_cnt2), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
